// File: rtl/gcbp_pkg.sv
// -----------------------------------------------------------------------------
// gcbp_pkg
// Shared definitions for the GCBP grid sequencer:
//   - gcbp_state_e      : sequencer FSM state encoding
//   - C_NUM_FRAME_SLOTS : number of rotating frame buffer slots
//   - C_*_LOC_RST       : slot assignment after reset
//   - C_DEF_*           : default grid geometry
// -----------------------------------------------------------------------------
package gcbp_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GAP    = 2'd1,
      S_ACTIVE = 2'd2,
      S_TAIL   = 2'd3
   } gcbp_state_e;

   localparam int C_NUM_FRAME_SLOTS = 3;

   localparam logic [1:0] C_NEXT_LOC_RST = 2'd0;
   localparam logic [1:0] C_CURR_LOC_RST = 2'd1;
   localparam logic [1:0] C_PREV_LOC_RST = 2'd2;

   localparam int C_DEF_NUM_VERT_SUBIMAGES = 4;
   localparam int C_DEF_NUM_HORI_SUBIMAGES = 4;
   localparam int C_DEF_SUBIMAGE_HEIGHT    = 64;
   localparam int C_DEF_EDGE_GAP           = 46;
   localparam int C_DEF_INTER_GAP          = 44;
   localparam int C_DEF_LINE_CNT_BITS      = 10;
   localparam int C_DEF_ADDR_BITS          = 9;

endpackage

// File: rtl/gcbp_frame_rotator.sv
// -----------------------------------------------------------------------------
// gcbp_frame_rotator
// Three-slot frame buffer rotation (next/curr/prev) plus a saturating count of
// how many complete frames are held in curr/prev.
// Ports:
//   i_clk, i_resetn    clock, asynchronous active-low reset
//   i_rotate           1-cycle request: a frame completed, rotate the slots
//   o_next_loc         slot being written
//   o_curr_loc         most recent complete frame
//   o_prev_loc         complete frame before curr
//   o_frames_ready     0..2 valid frames in curr/prev
// -----------------------------------------------------------------------------
module gcbp_frame_rotator
   import gcbp_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_resetn,
   input  logic       i_rotate,
   output logic [1:0] o_next_loc,
   output logic [1:0] o_curr_loc,
   output logic [1:0] o_prev_loc,
   output logic [1:0] o_frames_ready
);

   localparam logic [1:0] C_READY_MAX = 2'(C_NUM_FRAME_SLOTS - 1);

   logic [1:0] r_next_loc;
   logic [1:0] r_curr_loc;
   logic [1:0] r_prev_loc;
   logic [1:0] r_frames_ready;

   // Slot rotation: a permutation of the three slots, so they stay distinct.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_next_loc     <= C_NEXT_LOC_RST;
         r_curr_loc     <= C_CURR_LOC_RST;
         r_prev_loc     <= C_PREV_LOC_RST;
         r_frames_ready <= 2'd0;
      end else if (i_rotate) begin
         r_prev_loc <= r_curr_loc;
         r_curr_loc <= r_next_loc;
         r_next_loc <= r_prev_loc;
         if (r_frames_ready != C_READY_MAX) begin
            r_frames_ready <= r_frames_ready + 2'd1;
         end
      end
   end

   assign o_next_loc     = r_next_loc;
   assign o_curr_loc     = r_curr_loc;
   assign o_prev_loc     = r_prev_loc;
   assign o_frames_ready = r_frames_ready;

endmodule

// File: rtl/gcbp_grid_sequencer.sv
// -----------------------------------------------------------------------------
// gcbp_grid_sequencer
// Tracks video lines/fields, steps through an NV x NH grid of sub-image windows
// and produces the registered one-hot BRAM write enable and write address for
// each bit-plane line. Frame slots rotate only when a frame completed.
// Optional feature macro: GCBP_SEQ_ABORT_CNT_EN (aborted-frame counter).
// Ports:
//   i_clk, i_resetn              clock, asynchronous active-low reset
//   i_line_cnt                   current video line number
//   i_field_0                    field indicator, rising edge = new frame
//   i_line_valid                 1-cycle pulse: bit-plane line ready
//   i_hori_subimage_cnt          column of the presented line
//   o_bram_array_write_addr      next_loc*H + line offset in the window
//   o_bram_array_write_enable    one-hot, bit = vert*NH + hori
//   o_next/curr/prev_frame_loc   frame slot assignment
//   o_vert_subimage_cnt          active sub-image row
//   o_frame_done                 pulse on the last line of the last row
//   o_frames_ready               saturating count of valid frames (0..2)
//   o_abort_cnt                  aborted frames (0 when the feature is off)
// -----------------------------------------------------------------------------
module gcbp_grid_sequencer
   import gcbp_pkg::*;
#(
   parameter int C_NUM_VERT_SUBIMAGES = C_DEF_NUM_VERT_SUBIMAGES,
   parameter int C_NUM_HORI_SUBIMAGES = C_DEF_NUM_HORI_SUBIMAGES,
   parameter int C_SUBIMAGE_HEIGHT    = C_DEF_SUBIMAGE_HEIGHT,
   parameter int C_EDGE_GAP           = C_DEF_EDGE_GAP,
   parameter int C_INTER_GAP          = C_DEF_INTER_GAP,
   parameter int C_LINE_CNT_BITS      = C_DEF_LINE_CNT_BITS,
   parameter int C_ADDR_BITS          = C_DEF_ADDR_BITS,
   localparam int C_VB = (C_NUM_VERT_SUBIMAGES > 1) ? $clog2(C_NUM_VERT_SUBIMAGES) : 1,
   localparam int C_HB = (C_NUM_HORI_SUBIMAGES > 1) ? $clog2(C_NUM_HORI_SUBIMAGES) : 1,
   localparam int C_NWE = C_NUM_VERT_SUBIMAGES * C_NUM_HORI_SUBIMAGES
)(
   input  logic                       i_clk,
   input  logic                       i_resetn,
   input  logic [C_LINE_CNT_BITS-1:0] i_line_cnt,
   input  logic                       i_field_0,
   input  logic                       i_line_valid,
   input  logic [C_HB-1:0]            i_hori_subimage_cnt,
   output logic [C_ADDR_BITS-1:0]     o_bram_array_write_addr,
   output logic [C_NWE-1:0]           o_bram_array_write_enable,
   output logic [1:0]                 o_next_frame_loc,
   output logic [1:0]                 o_curr_frame_loc,
   output logic [1:0]                 o_prev_frame_loc,
   output logic [C_VB-1:0]            o_vert_subimage_cnt,
   output logic                       o_frame_done,
   output logic [1:0]                 o_frames_ready,
   output logic [7:0]                 o_abort_cnt
);

   // One extra bit keeps start+H-1 of the last row from wrapping.
   localparam int C_LW = C_LINE_CNT_BITS + 1;
   localparam logic [C_LW-1:0]        C_EDGE_W   = C_LW'(C_EDGE_GAP);
   localparam logic [C_LW-1:0]        C_STRIDE_W = C_LW'(C_SUBIMAGE_HEIGHT + C_INTER_GAP);
   localparam logic [C_LW-1:0]        C_HM1_W    = C_LW'(C_SUBIMAGE_HEIGHT - 1);
   localparam logic [C_VB-1:0]        C_LAST_ROW = C_VB'(C_NUM_VERT_SUBIMAGES - 1);
   localparam logic [C_VB-1:0]        C_ROW_ONE  = C_VB'(1);
   localparam logic [C_HB:0]          C_NH_W     = (C_HB + 1)'(C_NUM_HORI_SUBIMAGES);
   localparam logic [C_ADDR_BITS-1:0] C_H_A      = C_ADDR_BITS'(C_SUBIMAGE_HEIGHT);

   gcbp_state_e                r_state;
   logic [C_VB-1:0]            r_row;
   logic [C_LINE_CNT_BITS-1:0] r_line_cnt_d;
   logic                       r_field_d;
   logic [C_ADDR_BITS-1:0]     r_addr;
   logic [C_NWE-1:0]           r_we;
   logic                       r_frame_done;

   gcbp_state_e            w_state_f;
   gcbp_state_e            w_state_nxt;
   logic [C_VB-1:0]        w_row_f;
   logic [C_VB-1:0]        w_row_nxt;
   logic                   w_frame_done_nxt;
   logic                   w_rotate;
   logic                   w_new_line;
   logic                   w_new_frame;
   logic [C_LW-1:0]        w_line_ext;
   logic [C_LW-1:0]        w_prev_ext;
   logic [C_LW-1:0]        w_start;
   logic [C_LW-1:0]        w_last;
   logic                   w_in_window;
   logic                   w_col_ok;
   logic                   w_write;
   logic [C_ADDR_BITS-1:0] w_addr_nxt;
   logic [C_NWE-1:0]       w_we_nxt;
   int                     w_tile_idx;
   logic [1:0]             w_next_loc;

   assign w_new_line  = (i_line_cnt != r_line_cnt_d);
   assign w_new_frame = i_field_0 & ~r_field_d;
   assign w_line_ext  = {1'b0, i_line_cnt};
   assign w_prev_ext  = {1'b0, r_line_cnt_d};

   // Frame event is applied first so a coincident line is judged against row 0.
   always_comb begin
      w_state_f = r_state;
      w_row_f   = r_row;
      w_rotate  = 1'b0;
      if (w_new_frame) begin
         w_state_f = S_GAP;
         w_row_f   = {C_VB{1'b0}};
         w_rotate  = (r_state == S_TAIL);
      end else begin
         w_state_f = r_state;
         w_row_f   = r_row;
      end
   end

   assign w_start = C_EDGE_W + (C_LW'(w_row_f) * C_STRIDE_W);
   assign w_last  = w_start + C_HM1_W;

   // Line-driven state transitions; the active row is left on the line after its last.
   always_comb begin
      w_state_nxt      = w_state_f;
      w_row_nxt        = w_row_f;
      w_frame_done_nxt = 1'b0;
      if (w_new_line) begin
         case (w_state_f)
            S_GAP: begin
               if (w_line_ext == w_start) begin
                  w_state_nxt      = S_ACTIVE;
                  w_frame_done_nxt = (w_line_ext == w_last) && (w_row_f == C_LAST_ROW);
               end else begin
                  w_state_nxt = S_GAP;
               end
            end
            S_ACTIVE: begin
               if (w_prev_ext == w_last) begin
                  if (w_row_f == C_LAST_ROW) begin
                     w_state_nxt = S_TAIL;
                  end else begin
                     w_state_nxt = S_GAP;
                     w_row_nxt   = w_row_f + C_ROW_ONE;
                  end
               end else begin
                  w_frame_done_nxt = (w_line_ext == w_last) && (w_row_f == C_LAST_ROW);
               end
            end
            S_IDLE, S_TAIL: begin
               w_state_nxt = w_state_f;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_row_nxt   = {C_VB{1'b0}};
            end
         endcase
      end else begin
         w_state_nxt = w_state_f;
      end
   end

   assign w_in_window = (w_line_ext >= w_start) && (w_line_ext <= w_last);
   assign w_col_ok    = ({1'b0, i_hori_subimage_cnt} < C_NH_W);
   assign w_write     = i_line_valid && (w_state_nxt == S_ACTIVE) && w_in_window && w_col_ok;
   assign w_addr_nxt  = (C_ADDR_BITS'(w_next_loc) * C_H_A) + C_ADDR_BITS'(w_line_ext - w_start);

   // One-hot enable for the addressed tile.
   always_comb begin
      w_we_nxt   = {C_NWE{1'b0}};
      w_tile_idx = int'(w_row_f) * C_NUM_HORI_SUBIMAGES + int'(i_hori_subimage_cnt);
      for (int k = 0; k < C_NWE; k++) begin
         if (w_write && (k == w_tile_idx)) begin
            w_we_nxt[k] = 1'b1;
         end else begin
            w_we_nxt[k] = 1'b0;
         end
      end
   end

   // Sequencer state, edge-detect copies and registered write port.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state      <= S_IDLE;
         r_row        <= {C_VB{1'b0}};
         r_line_cnt_d <= {C_LINE_CNT_BITS{1'b0}};
         r_field_d    <= 1'b0;
         r_addr       <= {C_ADDR_BITS{1'b0}};
         r_we         <= {C_NWE{1'b0}};
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_row        <= w_row_nxt;
         r_line_cnt_d <= i_line_cnt;
         r_field_d    <= i_field_0;
         r_we         <= w_we_nxt;
         r_frame_done <= w_frame_done_nxt;
         if (w_write) begin
            r_addr <= w_addr_nxt;
         end
      end
   end

   gcbp_frame_rotator u_rotator (
      .i_clk          (i_clk),
      .i_resetn       (i_resetn),
      .i_rotate       (w_rotate),
      .o_next_loc     (w_next_loc),
      .o_curr_loc     (o_curr_frame_loc),
      .o_prev_loc     (o_prev_frame_loc),
      .o_frames_ready (o_frames_ready)
   );

`ifdef GCBP_SEQ_ABORT_CNT_EN
   logic       w_abort;
   logic [7:0] r_abort_cnt;

   // A new frame while a frame is still being collected discards it.
   assign w_abort = w_new_frame && ((r_state == S_GAP) || (r_state == S_ACTIVE));

   // Saturating aborted-frame counter, cleared only by reset.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_abort_cnt <= 8'd0;
      end else if (w_abort && (r_abort_cnt != 8'hFF)) begin
         r_abort_cnt <= r_abort_cnt + 8'd1;
      end
   end

   assign o_abort_cnt = r_abort_cnt;
`else
   assign o_abort_cnt = 8'd0;
`endif

   assign o_next_frame_loc          = w_next_loc;
   assign o_bram_array_write_addr   = r_addr;
   assign o_bram_array_write_enable = r_we;
   assign o_vert_subimage_cnt       = r_row;
   assign o_frame_done              = r_frame_done;

endmodule
